// File: rtl/rand_range_sampler_if.sv
// Output value stream of rand_range_sampler: FIFO head with valid/ready handshake.
interface rand_range_sampler_if #(
  parameter int S_WIDTH = 8
);
  logic [S_WIDTH-1:0] out_data_o;
  logic               out_valid_o;
  logic               out_ready_i;

  modport master (output out_data_o, output out_valid_o, input out_ready_i);
  modport slave  (input out_data_o, input out_valid_o, output out_ready_i);
endinterface

// File: rtl/rand_range_sampler.sv
// Seeds the LFSR, maps raw bytes into 0..255 / 0..3 / 1..40 (rejection sampling), buffers in a FIFO.
// Value sampled in cycle C is visible at C+1 when the FIFO is empty; full FIFO without pop drops values.
module rand_range_sampler #(
  parameter int S_WIDTH    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [S_WIDTH-1:0]   seed_i,
  input  logic [1:0]           mode_i,
  input  logic [S_WIDTH-1:0]   count_i,
  input  logic [S_WIDTH-1:0]   rand_i,
  output logic [S_WIDTH-1:0]   lfsr_seed_o,
  output logic                 lfsr_in_valid_o,
  rand_range_sampler_if.master out_if,
  output logic                 busy_o,
  output logic                 done_o
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEED, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [S_WIDTH-1:0] count_q, count_d;
  logic [S_WIDTH-1:0] prod_q, prod_d;
  logic [S_WIDTH-1:0] lfsr_seed_q, lfsr_seed_d;
  logic               seed_vld_q, seed_vld_d;
  logic               done_q, done_d;

  logic [PW-1:0]      wr_q, rd_q;
  logic [PW:0]        occ_q;
  logic [S_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic               empty, full, pop, push, accept;
  logic [S_WIDTH-1:0] mapped, mod40;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == (PW+1)'(FIFO_DEPTH));
  assign pop   = !empty && out_if.out_ready_i;
  assign push  = (state_q == RUN) && accept && (!full || pop);

  assign out_if.out_valid_o = !empty;
  assign out_if.out_data_o  = empty ? '0 : mem_q[rd_q];

  // Range mapping; raw values >= 240 are rejected in mode 2 so the mod-40 result stays unbiased.
  always_comb begin
    mod40 = rand_i;
    if      (rand_i >= S_WIDTH'(200)) mod40 = rand_i - S_WIDTH'(200);
    else if (rand_i >= S_WIDTH'(160)) mod40 = rand_i - S_WIDTH'(160);
    else if (rand_i >= S_WIDTH'(120)) mod40 = rand_i - S_WIDTH'(120);
    else if (rand_i >= S_WIDTH'(80))  mod40 = rand_i - S_WIDTH'(80);
    else if (rand_i >= S_WIDTH'(40))  mod40 = rand_i - S_WIDTH'(40);

    accept = 1'b1;
    mapped = rand_i;
    case (mode_q)
      2'd1: mapped = S_WIDTH'(rand_i[1:0]);
      2'd2: begin
        accept = (rand_i < S_WIDTH'(240));
        mapped = mod40 + S_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 2'd0;
      count_q     <= '0;
      prod_q      <= '0;
      lfsr_seed_q <= '0;
      seed_vld_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
      prod_q      <= prod_d;
      lfsr_seed_q <= lfsr_seed_d;
      seed_vld_q  <= seed_vld_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: if (start_i) begin
        mode_d  = (mode_i == 2'd3) ? 2'd0 : mode_i;
        count_d = count_i;
        prod_d  = '0;
        state_d = (count_i == '0) ? DRAIN : SEED;
      end
      SEED: state_d = RUN;
      RUN: if (push) begin
        prod_d = prod_q + S_WIDTH'(1);
        if (prod_q + S_WIDTH'(1) == count_q) state_d = DRAIN;
      end
      DRAIN: if (empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Seed strobe is registered; seed_i is only valid in the IDLE cycle that enters SEED.
  always_comb begin
    seed_vld_d  = (state_d == SEED);
    lfsr_seed_d = '0;
    if (seed_vld_d) lfsr_seed_d = (seed_i == '0) ? S_WIDTH'(8'hA5) : seed_i;
    done_d      = (state_q == DRAIN) && empty;
    busy_o          = (state_q != IDLE);
    done_o          = done_q;
    lfsr_seed_o     = lfsr_seed_q;
    lfsr_in_valid_o = seed_vld_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      if (push && !pop)      occ_q <= occ_q + (PW+1)'(1);
      else if (pop && !push) occ_q <= occ_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= mapped;
  end
endmodule

// File: tb/tb_rand_range_sampler.sv
// Scoreboard bench for rand_range_sampler with a Galois LFSR model (mask 0x9C) as random source.
module tb_rand_range_sampler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [7:0] seed_i, count_i, rand_i, rand_drv;
  logic [1:0] mode_i;
  logic [7:0] lfsr_seed_o;
  logic       lfsr_in_valid_o, busy_o, done_o;
  logic       use_lfsr;
  logic [7:0] lfsr_q = 8'h01;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  rand_range_sampler_if #(.S_WIDTH(8)) sb_if ();

  rand_range_sampler #(.S_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .seed_i(seed_i), .mode_i(mode_i),
    .count_i(count_i), .rand_i(rand_i), .lfsr_seed_o(lfsr_seed_o),
    .lfsr_in_valid_o(lfsr_in_valid_o), .out_if(sb_if), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'h9C) : (s >> 1);
  endfunction

  always @(posedge clk) lfsr_q <= lfsr_in_valid_o ? lfsr_step(lfsr_seed_o) : lfsr_step(lfsr_q);
  assign rand_i = use_lfsr ? lfsr_q : rand_drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done_o) done_cnt++;
    if (rst_n && sb_if.out_valid_o && sb_if.out_ready_i) begin
      pops++;
      chk("sb_has_entry", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        chk("out_data", sb_if.out_data_o, exp_v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [7:0] sd, input logic [1:0] md, input logic [7:0] cn);
    pops    = 0;
    seed_i  = sd;
    mode_i  = md;
    count_i = cn;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int exp_pops);
    for (int i = 0; i < 300 && !done_o; i++) tick();
    chk("done_seen", done_o, 1);
    chk("busy_at_done", busy_o, 0);
    chk("pops_at_done", pops, exp_pops);
    tick();
    chk("done_one_cycle", done_o, 0);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; seed_i = 8'h0; mode_i = 2'd0; count_i = 8'h0;
    rand_drv = 8'h0; use_lfsr = 1'b1; sb_if.out_ready_i = 1'b1;
    #12;
    chk("rst_valid", sb_if.out_valid_o, 0);
    chk("rst_data", sb_if.out_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_seed_vld", lfsr_in_valid_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Mode 0 with the LFSR, seed 1: 9C, 4E, 27.
    exp_q.push_back(8'h9C); exp_q.push_back(8'h4E); exp_q.push_back(8'h27);
    start_req(8'h01, 2'd0, 8'd3);
    chk("m0_seed_vld_t1", lfsr_in_valid_o, 1);
    chk("m0_seed_t1", lfsr_seed_o, 8'h01);
    chk("m0_busy_t1", busy_o, 1);
    tick();
    chk("m0_seed_vld_t2", lfsr_in_valid_o, 0);
    chk("m0_valid_t2", sb_if.out_valid_o, 0);
    tick();
    chk("m0_valid_t3", sb_if.out_valid_o, 1);
    chk("m0_data_t3", sb_if.out_data_o, 8'h9C);
    wait_done(3);

    // Mode 1 -> 0,2,3 ; mode 2 -> 37,39,40.
    exp_q.push_back(8'd0); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    start_req(8'h01, 2'd1, 8'd3);
    wait_done(3);
    exp_q.push_back(8'd37); exp_q.push_back(8'd39); exp_q.push_back(8'd40);
    start_req(8'h01, 2'd2, 8'd3);
    wait_done(3);

    // Rejection: 245 and 255 dropped, 80 -> 1, 239 -> 40.
    use_lfsr = 1'b0;
    exp_q.push_back(8'd1); exp_q.push_back(8'd40);
    start_req(8'h11, 2'd2, 8'd2);
    tick();
    rand_drv = 8'd245; tick();
    chk("rej_valid_245", sb_if.out_valid_o, 0);
    rand_drv = 8'd255; tick();
    chk("rej_valid_255", sb_if.out_valid_o, 0);
    rand_drv = 8'd80;  tick();
    chk("rej_data_80", sb_if.out_data_o, 8'd1);
    rand_drv = 8'd239; tick();
    chk("rej_data_239", sb_if.out_data_o, 8'd40);
    rand_drv = 8'd5;
    wait_done(2);

    // Backpressure: four buffered, 99s dropped while full, then 50 and 51.
    sb_if.out_ready_i = 1'b0;
    exp_q.push_back(8'd10); exp_q.push_back(8'd11); exp_q.push_back(8'd12);
    exp_q.push_back(8'd13); exp_q.push_back(8'd50); exp_q.push_back(8'd51);
    start_req(8'h22, 2'd0, 8'd6);
    tick();
    for (int i = 0; i < 4; i++) begin
      rand_drv = 8'(10 + i);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      rand_drv = 8'd99;
      start_i  = (i == 1);
      count_i  = 8'd0;
      mode_i   = 2'd1;
      tick();
      chk("bp_no_restart", lfsr_in_valid_o, 0);
    end
    start_i = 1'b0;
    chk("bp_busy", busy_o, 1);
    chk("bp_head", sb_if.out_data_o, 8'd10);
    sb_if.out_ready_i = 1'b1;
    rand_drv = 8'd50; tick();
    rand_drv = 8'd51; tick();
    rand_drv = 8'd77;
    wait_done(6);

    // count 0: no seed strobe, done at T+2.
    start_req(8'h33, 2'd0, 8'd0);
    chk("c0_seed_vld", lfsr_in_valid_o, 0);
    chk("c0_busy", busy_o, 1);
    chk("c0_done_t1", done_o, 0);
    tick();
    chk("c0_done_t2", done_o, 1);
    chk("c0_busy_t2", busy_o, 0);
    tick();
    chk("c0_done_t3", done_o, 0);

    // Seed 0 becomes A5; first LFSR value CE -> mode 1 gives 2.
    use_lfsr = 1'b1;
    exp_q.push_back(8'd2);
    start_req(8'h00, 2'd1, 8'd1);
    chk("s0_seed", lfsr_seed_o, 8'hA5);
    chk("s0_seed_vld", lfsr_in_valid_o, 1);
    wait_done(1);

    // Reset mid-RUN with three entries held.
    sb_if.out_ready_i = 1'b0;
    start_req(8'h01, 2'd0, 8'd8);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_valid_before", sb_if.out_valid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", sb_if.out_valid_o, 0);
    chk("mid_rst_data", sb_if.out_data_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_seed", lfsr_seed_o, 0);
    chk("mid_rst_seed_vld", lfsr_in_valid_o, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_valid", sb_if.out_valid_o, 0);
    sb_if.out_ready_i = 1'b1;
    tick(); tick();

    chk("sb_drained", exp_q.size(), 0);
    chk("done_total", done_cnt, 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rand_range_sampler.md
# rand_range_sampler

Control and post-processing stage that sits around the 8-bit LFSR random source. It seeds the LFSR on request and consumes the LFSR's free-running output. It maps each raw byte into one of the ranges used by the EC engine (0..255, 0..3 or 1..40), using rejection sampling where needed to avoid modulo bias. It buffers accepted values in a small FIFO behind a valid/ready output, and stops after a requested count.

## Interface
- S_WIDTH, 8, width of raw random byte and output data
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  request pulse; sampled only in IDLE
- seed_i  in  S_WIDTH  seed, latched with start_i
- mode_i  in  2  range select, latched with start_i: 0 → 0..255, 1 → 0..3, 2 → 1..40, 3 → treated as 0
- count_i  in  S_WIDTH  number of values to deliver, latched with start_i
- rand_i  in  S_WIDTH  raw byte from LFSR output register
- lfsr_seed_o  out  S_WIDTH  seed to LFSR (registered)
- lfsr_in_valid_o  out  1  one-cycle seed-load strobe to LFSR (registered)
- out_data_o  out  S_WIDTH  FIFO head value
- out_valid_o  out  1  FIFO not empty
- out_ready_i  in  1  consumer accepts the head when high together with out_valid_o
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse when the request is complete

## Operation
- FSM states: IDLE, SEED, RUN, DRAIN.
- **IDLE → SEED** on start_i. This cycle latches mode, count and seed.
  - A latched seed of 0 is replaced by 8'hA5, because an all-zero seed locks up the LFSR.
- **count_i = 0:** IDLE → DRAIN directly. No seed strobe is issued, and done_o pulses once the FIFO is empty.
- **SEED:** lfsr_in_valid_o = 1 and lfsr_seed_o = latched seed for exactly one cycle. Next state is RUN.
- **RUN:** rand_i is sampled every cycle. Mapping rules:
  - mode 0: value = raw, always accepted.
  - mode 1: value = raw[1:0], always accepted.
  - mode 2: accept only if raw < 240; value = (raw mod 40) + 1. The mod is computed by comparison/subtraction, with no divider. raw ≥ 240 is rejected.
- **Push condition:** accepted AND (FIFO not full OR pop in the same cycle).
  - An accepted value that finds the FIFO full with no simultaneous pop is dropped; the LFSR keeps running.
- **Produced counter:** 8-bit, increments on each push. When a push makes produced == count, the next state is DRAIN and no further pushes occur.
- **DRAIN:** wait for the FIFO to empty, then pulse done_o for 1 cycle and return to IDLE.
- start_i is ignored whenever busy_o = 1.
- **FIFO:** circular buffer with wrapping read/write pointers and an occupancy counter.
  - Pop when out_valid_o & out_ready_i.
  - Simultaneous push and pop leaves occupancy unchanged, including when full or empty.
  - Data on a pop-while-empty is undefined and no state changes.
- **Reset (any time, including mid-RUN):**
  - State returns to IDLE.
  - FIFO is emptied, counters are cleared.
  - All outputs go to 0: lfsr_seed_o, lfsr_in_valid_o, out_data_o, out_valid_o, busy_o, done_o.

## Timing
- start_i high in IDLE at cycle T:
  - T+1: SEED; lfsr_in_valid_o = 1, busy_o = 1.
  - T+2: RUN; first rand_i sample, which is the LFSR's seed-load result.
- A value sampled in cycle C is visible at out_data_o/out_valid_o in C+1 if the FIFO was empty.
- Max throughput is 1 value per cycle when out_ready_i stays high and no rejections occur.
- out_valid_o deasserts the cycle after the last entry is popped.
- done_o rises in the cycle after the FIFO becomes empty in DRAIN. busy_o falls in the same cycle done_o pulses.
- For count_i = 0, done_o occurs at T+2.

## Test plan
- **Reset:** assert rst_n = 0 mid-RUN with the FIFO holding 3 entries → all outputs 0 immediately; after release, state is IDLE and out_valid_o = 0.
- **Mode 0 with real LFSR:** LFSR attached, seed 8'h01, count 3, out_ready_i = 1 → lfsr_in_valid_o at T+1; outputs 0x9C, 0x4E, 0x27; done_o pulses once; busy_o falls.
- **Mode 1 and mode 2 with real LFSR:** same seed, count 3.
  - mode 1 → outputs 0, 2, 3.
  - mode 2 → outputs 37, 39, 40.
- **Rejection (bench drives rand_i):** mode 2, count 2, rand_i sequence 245, 255, 80, 239 → outputs 1, 40. The values 245 and 255 produce no push.
- **Backpressure:** mode 0, count 6, out_ready_i = 0 for 10 cycles.
  - The FIFO fills to 4 and further samples are dropped.
  - Raise out_ready_i → 4 buffered values appear, then 2 new samples; done_o pulses only after the 6th pop.
  - start_i pulsed while busy has no effect.
- **Edge cases:** count 0 → no lfsr_in_valid_o, done_o at T+2. Seed 0 → lfsr_seed_o = 8'hA5.
